multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle MIPS control unit that sequences the shared datapath (sign extender, shift-by-2, adder, 2:1 muxes, one ALU, one unified memory) over several clock cycles per instruction. It decodes the latched instruction's opcode and funct fields and drives every mux select and write enable each cycle through a Moore state machine. It sits between the instruction register and the datapath. It replaces the single-cycle combinational decoder.

## Interface
Parameters: none (opcode and funct encodings fixed below).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag, combinational, same cycle
- pcen  out  1  PC register load enable: pcwrite | (branch & zero)
- iord  out  1  memory address mux: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write enable
- irwrite  out  1  instruction register load enable
- regwrite  out  1  register file write enable
- regdst  out  1  write register mux: 0 = rt, 1 = rd
- memtoreg  out  1  write data mux: 0 = ALUOut, 1 = MDR
- alusrca  out  1  ALU A mux: 0 = PC, 1 = reg A
- alusrcb  out  2  ALU B: 00 = reg B, 01 = const 4, 10 = signext imm, 11 = signext imm shl 2
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- state  out  4  current state (debug / verification)

## Operation
- State register 4 bits. Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11. Codes 12–15 are illegal and go to FETCH next cycle with all enables 0.
- Outputs are decoded from the state only (Moore), except pcen, which also uses zero. Unlisted outputs are 0. alucontrol defaults to 010.
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, add. Next state: DECODE.
- DECODE: alusrcb=11, add (precomputes the branch target into ALUOut). Next state by op:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 → RTEX
  - 000100 (beq) → BEQEX
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JEX
  - any other op → FETCH (executes as a nop)
- MEMADR: alusrca=1, alusrcb=10, add. Next: lw → MEMRD, sw → MEMWR.
- MEMRD: iord=1. Next: MEMWB.
- MEMWB: memtoreg=1, regwrite=1. Next: FETCH.
- MEMWR: iord=1, memwrite=1. Next: FETCH.
- RTEX: alusrca=1, alusrcb=00, alucontrol from funct. Next: RTWB.
  - funct mapping: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
  - Unknown funct → 010.
- RTWB: regdst=1, regwrite=1. Next: FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1. Next: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next: ADDIWB.
- ADDIWB: regwrite=1 (regdst=0, memtoreg=0). Next: FETCH.
- JEX: pcsrc=10, pcwrite=1. Next: FETCH.
- op and funct are sampled only in DECODE, MEMADR and RTEX. The IR is stable after FETCH, so no internal latching is needed.

## Timing
- Reset: while rst_n=0, state=FETCH immediately (asynchronous). pcen, irwrite, memwrite and regwrite are forced to 0. All other outputs equal the FETCH values.
- First rising edge after rst_n deasserts executes FETCH.
- Cycles per instruction, FETCH through the last state inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
- pcen in BEQEX follows zero combinationally within the cycle. In every other state, pcen = pcwrite.
- At most one of regwrite, memwrite and irwrite is high in any cycle.
- Reset asserted mid-instruction: state goes to FETCH asynchronously and all enables drop at once. A pending write is lost and must not occur.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with op=100011 → state=0 and pcen=irwrite=memwrite=regwrite=0 throughout. Release → state sequence 0,1,2,3,4,0.
- lw/sw: op=100011 → MEMRD has iord=1. MEMWB has regwrite=1, memtoreg=1, regdst=0. op=101011 → state sequence 0,1,2,5,0; MEMWR has memwrite=1, iord=1, regwrite=0.
- R-type: op=000000 with funct 100010 → RTEX alucontrol=110, RTWB regwrite=1, regdst=1. Repeat for funct 100101 (001), 101010 (111) and 111111 (010).
- beq: op=000100, zero=1 in BEQEX → pcen=1, pcsrc=01, alucontrol=110. With zero=0 → pcen=0. Both cases return to FETCH after 3 cycles.
- j and unknown op: op=000010 → JEX with pcsrc=10, pcen=1. op=111111 → state sequence 0,1,0 with no write enable asserted in DECODE.
- Reset mid-op: assert rst_n=0 asynchronously while in MEMWR → memwrite falls in the same cycle without waiting for a clock edge, and state=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit.
// A Moore state machine steps the shared datapath through fetch, decode and
// the per-instruction execute/memory/writeback states. All outputs come from
// the current state. The exception is pcen, which also folds in the ALU zero
// flag for beq. The write enables are gated by rst_n. This makes a write that
// is in flight stop at once when reset is asserted.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEX   = 4'd6,
        RTWB   = 4'd7,
        BEQEX  = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JEX    = 4'd11
    } state_t;

    state_t state_q, state_d;

    logic pcwrite_s, branch_s, irwrite_s, memwrite_s, regwrite_s;

    // Next-state selection. Illegal codes and unknown opcodes fall back to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYP:      state_d = RTEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_d = MEMWB;
            RTEX:   state_d = RTWB;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // State register. Asynchronous reset puts the machine back in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode. Any field not set here stays at 0, and the ALU defaults to add.
    always_comb begin
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        case (state_q)
            FETCH: begin
                irwrite_s = 1'b1;
                pcwrite_s = 1'b1;
                alusrcb   = 2'b01;
            end
            DECODE: alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:  iord = 1'b1;
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            RTEX: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucontrol = ALU_SUB;
                    6'b100100: alucontrol = ALU_AND;
                    6'b100101: alucontrol = ALU_OR;
                    6'b101010: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            RTWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch_s   = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: regwrite_s = 1'b1;
            JEX: begin
                pcsrc     = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are held low for as long as reset is asserted, without waiting for a clock edge.
    assign pcen     = rst_n & (pcwrite_s | (branch_s & zero));
    assign irwrite  = rst_n & irwrite_s;
    assign memwrite = rst_n & memwrite_s;
    assign regwrite = rst_n & regwrite_s;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl.
// The reference model expands each instruction into a queue of expected
// per-cycle control words. Hand-written tables fix the state sequences and
// the key ALU codes independently of the model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // One expected cycle of control: state plus each control field.
    typedef struct packed {
        logic [3:0] st;
        logic       pcw, br, iord, memw, irw, regw, regdst, m2r, asa;
        logic [1:0] asb, pcsrc;
        logic [2:0] alu;
    } exp_t;

    exp_t q[$];

    // Table record: instruction inputs plus hand-derived expectations.
    typedef struct {
        logic [5:0]       op;
        logic [5:0]       funct;
        int               zmode;    // 0/1 fixed zero, 2 random
        int               len;
        logic [4:0][3:0]  st;       // st[i] = state in cycle i
        int               alu_idx;  // cycle whose alucontrol is checked, -1 none
        logic [2:0]       alu;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [18:0] dut_vec();
        return {pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
                alusrcb, pcsrc, alucontrol, state};
    endfunction

    function automatic logic [18:0] exp_vec(input exp_t r, input logic z);
        return {r.pcw | (r.br & z), r.iord, r.memw, r.irw, r.regw, r.regdst, r.m2r, r.asa,
                r.asb, r.pcsrc, r.alu, r.st};
    endfunction

    function automatic exp_t base(input logic [3:0] s);
        exp_t r;
        r = '0;
        r.st  = s;
        r.alu = 3'b010;
        return r;
    endfunction

    // Expand one instruction into its expected cycle-by-cycle control words.
    task automatic gen(input logic [5:0] o, input logic [5:0] f);
        exp_t r;
        q.delete();
        r = base(4'd0); r.irw = 1; r.pcw = 1; r.asb = 2'b01; q.push_back(r);
        r = base(4'd1); r.asb = 2'b11; q.push_back(r);
        if (o == 6'b100011 || o == 6'b101011) begin
            r = base(4'd2); r.asa = 1; r.asb = 2'b10; q.push_back(r);
            if (o == 6'b100011) begin
                r = base(4'd3); r.iord = 1; q.push_back(r);
                r = base(4'd4); r.m2r = 1; r.regw = 1; q.push_back(r);
            end else begin
                r = base(4'd5); r.iord = 1; r.memw = 1; q.push_back(r);
            end
        end else if (o == 6'b000000) begin
            r = base(4'd6); r.asa = 1;
            r.alu = (f == 6'b100010) ? 3'b110 :
                    (f == 6'b100100) ? 3'b000 :
                    (f == 6'b100101) ? 3'b001 :
                    (f == 6'b101010) ? 3'b111 : 3'b010;
            q.push_back(r);
            r = base(4'd7); r.regdst = 1; r.regw = 1; q.push_back(r);
        end else if (o == 6'b000100) begin
            r = base(4'd8); r.asa = 1; r.alu = 3'b110; r.pcsrc = 2'b01; r.br = 1; q.push_back(r);
        end else if (o == 6'b001000) begin
            r = base(4'd9); r.asa = 1; r.asb = 2'b10; q.push_back(r);
            r = base(4'd10); r.regw = 1; q.push_back(r);
        end else if (o == 6'b000010) begin
            r = base(4'd11); r.pcsrc = 2'b10; r.pcw = 1; q.push_back(r);
        end
    endtask

    // Run one instruction starting #1 after a rising edge with the DUT in FETCH.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                             input bit use_tbl, input logic [4:0][3:0] tst,
                             input int alu_idx, input logic [2:0] alu_exp);
        int n;
        op    = o;
        funct = f;
        gen(o, f);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            chk("ctrl_word", 32'(dut_vec()), 32'(exp_vec(q[i], zero)));
            if (use_tbl) begin
                chk("state_seq", 32'(state), 32'(tst[i]));
                if (i == alu_idx) chk("alucontrol", 32'(alucontrol), 32'(alu_exp));
            end
            @(posedge clk);
            #1;
        end
        $display("instr op=%b funct=%b cycles=%0d", o, f, n);
    endtask

    logic [5:0] ops[7];
    logic [5:0] fns[5];

    initial begin
        logic [5:0] ro, rf;

        tbl[0]  = '{6'b100011, 6'b000000, 0, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, -1, 3'b010};
        tbl[1]  = '{6'b101011, 6'b000000, 0, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 2, 3'b010};
        tbl[2]  = '{6'b000000, 6'b100000, 0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 2, 3'b010};
        tbl[3]  = '{6'b000000, 6'b100010, 0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 2, 3'b110};
        tbl[4]  = '{6'b000000, 6'b100100, 0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 2, 3'b000};
        tbl[5]  = '{6'b000000, 6'b100101, 0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 2, 3'b001};
        tbl[6]  = '{6'b000000, 6'b101010, 0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 2, 3'b111};
        tbl[7]  = '{6'b000000, 6'b111111, 0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 2, 3'b010};
        tbl[8]  = '{6'b000100, 6'b000000, 1, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}, 2, 3'b110};
        tbl[9]  = '{6'b000100, 6'b000000, 0, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}, 2, 3'b110};
        tbl[10] = '{6'b001000, 6'b000000, 0, 4, {4'd0, 4'd10, 4'd9, 4'd1, 4'd0}, 2, 3'b010};
        tbl[11] = '{6'b000010, 6'b000000, 0, 3, {4'd0, 4'd0, 4'd11, 4'd1, 4'd0}, -1, 3'b010};
        tbl[12] = '{6'b111111, 6'b000000, 0, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 1, 3'b010};

        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        // Reset held for three cycles: state must be FETCH, and every enable is low.
        rst_n = 1'b0;
        op    = 6'b100011;
        funct = 6'b000000;
        zero  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_word", 32'(dut_vec()),
                32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     2'b01, 2'b00, 3'b010, 4'd0}));
        end
        #2 rst_n = 1'b1;

        // First instruction after release: lw runs through 0,1,2,3,4.
        run_instr(6'b100011, 6'b000000, 0, 1'b1, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, -1, 3'b010);

        // Directed table.
        for (int t = 0; t < 13; t++) begin
            run_instr(tbl[t].op, tbl[t].funct, tbl[t].zmode, 1'b1, tbl[t].st,
                      tbl[t].alu_idx, tbl[t].alu);
        end

        // Reset asserted mid-store: memwrite must drop without a clock edge.
        op = 6'b101011;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        #1;
        chk("memwr_before_rst", 32'({memwrite, iord, state}), 32'({1'b1, 1'b1, 4'd5}));
        rst_n = 1'b0;
        #1;
        chk("memwr_async_rst", 32'({pcen, irwrite, memwrite, regwrite, state}),
            32'({4'b0000, 4'd0}));
        @(posedge clk);
        #1;
        chk("memwr_rst_held", 32'({pcen, irwrite, memwrite, regwrite, state}),
            32'({4'b0000, 4'd0}));
        #2 rst_n = 1'b1;
        run_instr(6'b100011, 6'b000000, 0, 1'b1, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, -1, 3'b010);

        // Random instruction stream against the model.
        for (int k = 0; k < 150; k++) begin
            ro = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) ro = 6'($urandom);
            rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(ro, rf, 2, 1'b0, '0, -1, 3'b010);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
